// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the 4-bit Fibonacci PRBS generator/checker pair
// (x^4 + x^3 + 1, shift-left, feedback from the two top bits).
package prbs_checker_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Feedback taps, counted down from the MSB, so any WIDTH keeps the same shape.
    localparam int TAP_HI_OFS = 1;
    localparam int TAP_LO_OFS = 2;

    // Counter widths sized for the largest legal LOCK_CNT / UNLOCK_CNT values.
    localparam int MATCH_W = 8;
    localparam int MISS_W  = 4;

    function automatic logic lfsr_feedback(input logic hi, input logic lo);
        return hi ^ lo;
    endfunction

endpackage

// File: rtl/prbs_checker_lfsr_step.sv
// One LFSR step: predicts the generator's next bit and shifts a chosen bit in.
// Shared with the generator so both ends always use the same taps.
module prbs_lfsr_step
    import prbs_checker_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] sr_in,
    input  logic             shift_bit,
    output logic [WIDTH-1:0] sr_out,
    output logic             pred
);

    assign pred   = lfsr_feedback(sr_in[WIDTH-TAP_HI_OFS], sr_in[WIDTH-1-TAP_LO_OFS+1]);
    assign sr_out = {sr_in[WIDTH-2:0], shift_bit};

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds from the line, verifies, then flywheels
// on its own prediction while counting bit errors.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             sticky_err
);

    localparam int FILL_W = $clog2(WIDTH + 1);

    localparam logic [FILL_W-1:0]  FILL_DONE  = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] MATCH_DONE = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  MISS_DONE  = MISS_W'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    state_t             state;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]   sr_next;
    logic               pred;
    logic               shift_bit;
    logic               mismatch;
    logic [FILL_W-1:0]  fill;
    logic [MATCH_W-1:0] match;
    logic [MISS_W-1:0]  miss;
    logic [FILL_W-1:0]  fill_inc;
    logic [MATCH_W-1:0] match_inc;
    logic [MISS_W-1:0]  miss_inc;

    // Once locked, the register runs on its own prediction so line errors
    // never corrupt the reference.
    assign shift_bit = (state == LOCKED) ? pred : bit_in;
    assign mismatch  = (bit_in != pred);
    assign fill_inc  = fill + FILL_W'(1);
    assign match_inc = match + MATCH_W'(1);
    assign miss_inc  = miss + MISS_W'(1);

    prbs_lfsr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .sr_in    (sr),
        .shift_bit(shift_bit),
        .sr_out   (sr_next),
        .pred     (pred)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SEED;
            sr         <= '0;
            fill       <= '0;
            match      <= '0;
            miss       <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            sticky_err <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (bit_valid) begin
                sr <= sr_next;
                case (state)
                    SEED: begin
                        if (fill_inc == FILL_DONE) begin
                            fill <= '0;
                            // An all-zero register is the LFSR's dead state; keep seeding.
                            if (sr_next != '0) begin
                                state <= VERIFY;
                                match <= '0;
                            end
                        end else begin
                            fill <= fill_inc;
                        end
                    end
                    VERIFY: begin
                        if (mismatch) begin
                            state <= SEED;
                            fill  <= '0;
                        end else if (match_inc == MATCH_DONE) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            miss   <= '0;
                        end else begin
                            match <= match_inc;
                        end
                    end
                    LOCKED: begin
                        if (mismatch) begin
                            err_pulse  <= 1'b1;
                            sticky_err <= 1'b1;
                            if (err_count != CNT_MAX) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (miss_inc == MISS_DONE) begin
                                state  <= SEED;
                                locked <= 1'b0;
                                fill   <= '0;
                                miss   <= '0;
                            end else begin
                                miss <= miss_inc;
                            end
                        end else begin
                            miss <= '0;
                        end
                    end
                    default: begin
                        state  <= SEED;
                        locked <= 1'b0;
                        fill   <= '0;
                    end
                endcase
            end
            // Clearing takes priority over an error counted in the same cycle.
            if (clr_cnt) begin
                err_count  <= '0;
                sticky_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised self-checking bench for prbs_checker against a queue-based reference
// model built on the recurrence x[n] = x[n-3] ^ x[n-4].
module tb_prbs_checker;

    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_valid;
    logic        bit_in;
    logic        clr_cnt;
    logic        locked, err_pulse, sticky_err;
    logic [15:0] err_count;
    logic        locked_s, err_pulse_s, sticky_err_s;
    logic [3:0]  err_count_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .sticky_err(sticky_err)
    );

    prbs_checker #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s), .sticky_err(sticky_err_s)
    );

    // Generator output from seed 4'b1011, taken directly as a bit table.
    bit seq [15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                     1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int seq_idx;

    // Reference model state: mode 0 = seeding, 1 = verifying, 2 = locked.
    int m_mode, m_fill, m_match, m_miss, m_cnt, m_cnt_s;
    bit m_sticky, m_pulse;
    bit m_hist[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit nextClean();
        bit b = seq[seq_idx];
        seq_idx = (seq_idx + 1) % 15;
        return b;
    endfunction

    task automatic modelReset();
        m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0;
        m_cnt = 0; m_cnt_s = 0; m_sticky = 0; m_pulse = 0;
        m_hist = '{1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    task automatic modelStep(input bit bv, input bit b, input bit clr);
        bit p;
        m_pulse = 0;
        if (bv) begin
            p = m_hist[0] ^ m_hist[1];
            void'(m_hist.pop_front());
            if (m_mode == 2) m_hist.push_back(p);
            else             m_hist.push_back(b);
            if (m_mode == 0) begin
                m_fill++;
                if (m_fill == 4) begin
                    m_fill = 0;
                    if (m_hist[0] | m_hist[1] | m_hist[2] | m_hist[3]) begin
                        m_mode = 1; m_match = 0;
                    end
                end
            end else if (m_mode == 1) begin
                if (b == p) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
                end else begin
                    m_mode = 0; m_fill = 0;
                end
            end else begin
                if (b != p) begin
                    m_pulse = 1; m_sticky = 1; m_miss++;
                    m_cnt   = (m_cnt   < 65535) ? m_cnt + 1   : 65535;
                    m_cnt_s = (m_cnt_s < 15)    ? m_cnt_s + 1 : 15;
                    if (m_miss == UNLOCK_CNT) begin m_mode = 0; m_fill = 0; end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (clr) begin m_cnt = 0; m_cnt_s = 0; m_sticky = 0; end
    endtask

    task automatic applyStimulus(input bit bv, input bit b, input bit clr);
        bit_valid = bv; bit_in = b; clr_cnt = clr;
        modelStep(bv, b, clr);
        @(posedge clk);
        #1;
        checkOutput("locked",       locked,       32'(m_mode == 2));
        checkOutput("err_pulse",    err_pulse,    32'(m_pulse));
        checkOutput("err_count",    err_count,    32'(m_cnt));
        checkOutput("sticky_err",   sticky_err,   32'(m_sticky));
        checkOutput("err_count_s",  err_count_s,  32'(m_cnt_s));
        checkOutput("sticky_err_s", sticky_err_s, 32'(m_sticky));
        checkOutput("locked_s",     locked_s,     32'(m_mode == 2));
        checkOutput("err_pulse_s",  err_pulse_s,  32'(m_pulse));
    endtask

    task automatic sendClean(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, nextClean(), 1'b0);
    endtask

    task automatic sendError();
        applyStimulus(1'b1, ~nextClean(), 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;
        modelReset();
        seq_idx = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int err_den;
        doReset();
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_pulse", err_pulse, 0);
        checkOutput("reset_count", err_count, 0);
        checkOutput("reset_sticky", sticky_err, 0);

        // Clean lock: exactly 12 valid bits to lock, then a long error-free run.
        sendClean(11);
        checkOutput("lock_pre", locked, 0);
        sendClean(1);
        checkOutput("lock_at_12", locked, 1);
        sendClean(1000);
        checkOutput("clean_count", err_count, 0);

        // Single error: flywheel keeps the reference intact.
        sendError();
        checkOutput("single_pulse", err_pulse, 1);
        sendClean(20);
        checkOutput("single_count", err_count, 1);
        checkOutput("single_sticky", sticky_err, 1);
        checkOutput("single_locked", locked, 1);

        // Loss of lock after four consecutive errors, then relock.
        applyStimulus(1'b1, nextClean(), 1'b1);
        for (int i = 0; i < 3; i++) sendError();
        checkOutput("unlock_pre", locked, 1);
        sendError();
        checkOutput("unlock_count", err_count, 4);
        checkOutput("unlock_locked", locked, 0);
        sendClean(11);
        checkOutput("relock_pre", locked, 0);
        sendClean(1);
        checkOutput("relock", locked, 1);

        // Saturation of the narrow instance, then clear colliding with an error.
        applyStimulus(1'b1, nextClean(), 1'b1);
        for (int i = 0; i < 20; i++) begin
            sendError();
            sendClean(1);
        end
        checkOutput("sat_hold", err_count_s, 4'hF);
        checkOutput("sat_wide", err_count, 20);
        applyStimulus(1'b1, ~nextClean(), 1'b1);
        checkOutput("clr_pulse", err_pulse, 1);
        checkOutput("clr_count", err_count, 0);
        checkOutput("clr_sticky", sticky_err, 0);

        // Asynchronous reset in the middle of LOCKED.
        sendError();
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_locked", locked, 0);
        checkOutput("arst_pulse", err_pulse, 0);
        checkOutput("arst_count", err_count, 0);
        checkOutput("arst_sticky", sticky_err, 0);
        doReset();

        // All-zero stream never leaves seeding.
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("zero_locked", locked, 0);
        checkOutput("zero_count", err_count, 0);

        // Sparse valid: 12 valid bits over 24 cycles.
        doReset();
        for (int c = 0; c < 24; c++) begin
            if (c % 2 == 0) applyStimulus(1'b1, nextClean(), 1'b0);
            else            applyStimulus(1'b0, 1'b0, 1'b0);
            if (c == 20) checkOutput("sparse_pre", locked, 0);
        end
        checkOutput("sparse_lock", locked, 1);

        // Error at the fifth verify bit drops back to seeding, uncounted.
        doReset();
        sendClean(8);
        sendError();
        checkOutput("verr_locked", locked, 0);
        checkOutput("verr_count", err_count, 0);
        sendClean(11);
        checkOutput("verr_relock_pre", locked, 0);
        sendClean(1);
        checkOutput("verr_relock", locked, 1);

        // Randomised traffic with varying error density, gaps, junk and clears.
        err_den = 0;
        for (int c = 0; c < 4000; c++) begin
            bit bv, b, clr;
            if (c % 500 == 0) err_den = (c / 500) % 3 == 0 ? 0 : ((c / 500) % 3 == 1 ? 40 : 3);
            bv  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 96) == 0);
            b   = 1'b0;
            if (bv) begin
                b = nextClean();
                if (c >= 2000 && c < 2060) b = 1'($urandom_range(0, 1));
                else if (err_den != 0 && $urandom_range(1, err_den) == 1) b = ~b;
            end
            applyStimulus(bv, b, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
